// File: rtl/ysyx_22040386_mem_arb.sv
// ---------------------------------------------------------------------------
// ysyx_22040386_mem_arb
//
// Shares one memory request/response port between instruction fetch (IF) and
// load/store (LS). Only one transaction is in flight at a time. The FSM runs
// IDLE -> ISSUE -> WAIT -> IDLE.
//
// Arbitration happens in IDLE. A lone requester is granted directly. When both
// request, the one that was not granted last time wins. The granted request's
// fields are latched, so requesters only need to hold them until they see
// req_ready.
//
// A timeout counter bounds the time spent in ISSUE+WAIT. The owner then gets an
// error response instead of hanging forever.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   if_req_*  / if_resp_*         fetch request (read only) and response
//   ls_req_*  / ls_resp_*         load/store request and response
//   mem_req_* / mem_resp_*        shared memory port
//   busy                          a transaction is in flight (state != IDLE)
//
// Parameter
//   TIMEOUT   number of ISSUE+WAIT cycles allowed before the abort cycle.
//             The counter is 8 bits, so TIMEOUT must be in 0..255.
// ---------------------------------------------------------------------------
module ysyx_22040386_mem_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_resp_valid,
  output logic [63:0] if_resp_data,
  output logic        if_resp_err,

  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [63:0] ls_req_addr,
  input  logic        ls_req_wen,
  input  logic [63:0] ls_req_wdata,
  input  logic [7:0]  ls_req_wmask,
  output logic        ls_resp_valid,
  output logic [63:0] ls_resp_data,
  output logic        ls_resp_err,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,

  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  // Owner / last-grant encoding. It doubles as the index into resp_sel.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;

  logic        in_idle;
  logic        active;
  logic        grant_if;
  logic        grant_ls;
  logic        grant_any;
  logic        timeout_hit;
  logic        resp_hit;
  logic        abort;
  logic        finish;
  logic [63:0] resp_data;
  logic [1:0]  resp_sel;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  // Every output is gated with !rst. The registers only clear at the first
  // reset edge, so without the gate stale values could appear while rst is
  // held high.
  assign in_idle = (state_q == S_IDLE) & ~rst;
  assign active  = (state_q != S_IDLE) & ~rst;

  // On a tie, the requester that is not last_grant wins. With a single
  // requester, last_grant is irrelevant.
  assign grant_if = in_idle & if_req_valid &
                    (~ls_req_valid | (last_grant_q == OWN_LS));
  assign grant_ls = in_idle & ls_req_valid &
                    (~if_req_valid | (last_grant_q == OWN_IF));
  assign grant_any = grant_if | grant_ls;

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  // -------------------------------------------------------------------------
  // Completion: normal response or timeout abort
  // -------------------------------------------------------------------------
  // cnt_q counts ISSUE/WAIT cycles already spent. When it equals TIMEOUT, the
  // transaction has used its whole allowance and this cycle aborts.
  assign timeout_hit = active & (cnt_q == TIMEOUT_C);

  // Responses count only in WAIT. A response that lands on the timeout cycle
  // still wins over the abort.
  assign resp_hit = (state_q == S_WAIT) & ~rst & mem_resp_valid;
  assign abort    = timeout_hit & ~resp_hit;
  assign finish   = resp_hit | abort;

  // Write responses and aborts return zero data.
  assign resp_data = (resp_hit & ~wen_q) ? mem_resp_data : 64'd0;

  // Steer the completion pulse to the owner only.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp_sel
    assign resp_sel[gi] = finish & (owner_q == 1'(gi));
  end

  assign if_resp_valid = resp_sel[OWN_IF];
  assign if_resp_err   = resp_sel[OWN_IF] & abort;
  assign if_resp_data  = resp_sel[OWN_IF] ? resp_data : 64'd0;

  assign ls_resp_valid = resp_sel[OWN_LS];
  assign ls_resp_err   = resp_sel[OWN_LS] & abort;
  assign ls_resp_data  = resp_sel[OWN_LS] ? resp_data : 64'd0;

  // -------------------------------------------------------------------------
  // Memory request port
  // -------------------------------------------------------------------------
  // The request is withdrawn on the abort cycle. Memory can then never accept
  // a transaction that the owner has already been told failed.
  assign mem_req_valid = (state_q == S_ISSUE) & ~rst & ~timeout_hit;
  assign mem_req_addr  = rst ? 64'd0 : addr_q;
  assign mem_req_wen   = ~rst & wen_q;
  assign mem_req_wdata = rst ? 64'd0 : wdata_q;
  assign mem_req_wmask = rst ? 8'd0 : wmask_q;

  assign busy = active;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;

    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d      = S_ISSUE;
          owner_d      = grant_ls ? OWN_LS : OWN_IF;
          last_grant_d = grant_ls ? OWN_LS : OWN_IF;
          cnt_d        = 8'd0;
          if (grant_ls) begin
            addr_d  = ls_req_addr;
            wen_d   = ls_req_wen;
            wdata_d = ls_req_wdata;
            wmask_d = ls_req_wmask;
          end else begin
            // Fetches are always plain reads.
            addr_d  = if_req_addr;
            wen_d   = 1'b0;
            wdata_d = 64'd0;
            wmask_d = 8'd0;
          end
        end
      end

      S_ISSUE: begin
        cnt_d = cnt_q + 8'd1;
        if (timeout_hit) begin
          state_d = S_IDLE;
        end else if (mem_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (finish) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // On reset, last_grant is set to LS so that IF wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_LS;
      cnt_q        <= 8'd0;
      addr_q       <= 64'd0;
      wen_q        <= 1'b0;
      wdata_q      <= 64'd0;
      wmask_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040386_mem_arb.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_22040386_mem_arb.
//
// Every sampled cycle is compared against a transaction-level reference model
// (model_step). The model tracks one in-flight transaction as a record with
// an "accepted by memory" flag and an age in cycles.
//
// On top of that model there are:
//   - a cycle table for reset, minimum latency and round-robin behaviour,
//   - hand-written multi-cycle sequences (stalled write, timeouts,
//     response on the timeout cycle, reset while in WAIT),
//   - randomized traffic with occasional resets.
// ---------------------------------------------------------------------------
module tb_ysyx_22040386_mem_arb;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_resp_valid, if_resp_err;
  logic [63:0] if_resp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_wen;
  logic [63:0] ls_req_addr, ls_req_wdata;
  logic [7:0]  ls_req_wmask;
  logic        ls_resp_valid, ls_resp_err;
  logic [63:0] ls_resp_data;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        busy;

  always #5 clk = ~clk;

  ysyx_22040386_mem_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_req_addr(if_req_addr), .if_resp_valid(if_resp_valid),
    .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
    .ls_req_addr(ls_req_addr), .ls_req_wen(ls_req_wen),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .ls_resp_err(ls_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the single in-flight transaction.
  bit          m_busy    = 1'b0;
  bit          m_owner   = 1'b0;  // 0 = IF, 1 = LS
  bit          m_issued  = 1'b0;  // memory has taken the request
  bit          m_last    = 1'b1;  // last granted requester
  int          m_age     = 0;     // cycles spent since the grant cycle
  logic [63:0] m_addr    = '0;
  logic        m_wen     = 1'b0;
  logic [63:0] m_wdata   = '0;
  logic [7:0]  m_wmask   = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare this cycle's outputs with the model, then advance the model
  // across the coming clock edge.
  task automatic model_step();
    logic        e_ifr, e_lsr, e_ifv, e_lsv, e_ife, e_lse, e_mv, e_busy;
    logic [63:0] e_ifd, e_lsd, rdata;
    int          win;
    bit          done, err, newly;
    e_ifr = 0; e_lsr = 0; e_ifv = 0; e_lsv = 0; e_ife = 0; e_lse = 0;
    e_mv = 0; e_busy = 0; e_ifd = '0; e_lsd = '0; rdata = '0;
    win = -1; done = 0; err = 0; newly = 0;
    if (rst) begin
      m_busy = 0; m_last = 1; m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0;
    end else if (!m_busy) begin
      if (if_req_valid && ls_req_valid) win = m_last ? 0 : 1;
      else if (if_req_valid) win = 0;
      else if (ls_req_valid) win = 1;
      e_ifr = (win == 0);
      e_lsr = (win == 1);
    end else begin
      e_busy = 1;
      if (!m_issued) begin
        if (m_age == TO) begin
          done = 1; err = 1;
        end else begin
          e_mv = 1;
          newly = mem_req_ready;
        end
      end else if (mem_resp_valid) begin
        done = 1;
        rdata = m_wen ? 64'd0 : mem_resp_data;
      end else if (m_age == TO) begin
        done = 1; err = 1;
      end
      if (done && !m_owner) begin e_ifv = 1; e_ife = err; e_ifd = rdata; end
      if (done &&  m_owner) begin e_lsv = 1; e_lse = err; e_lsd = rdata; end
    end
    chk("if_req_ready",  if_req_ready,  e_ifr);
    chk("ls_req_ready",  ls_req_ready,  e_lsr);
    chk("if_resp_valid", if_resp_valid, e_ifv);
    chk("if_resp_err",   if_resp_err,   e_ife);
    chk("if_resp_data",  if_resp_data,  e_ifd);
    chk("ls_resp_valid", ls_resp_valid, e_lsv);
    chk("ls_resp_err",   ls_resp_err,   e_lse);
    chk("ls_resp_data",  ls_resp_data,  e_lsd);
    chk("mem_req_valid", mem_req_valid, e_mv);
    chk("mem_req_addr",  mem_req_addr,  m_addr);
    chk("mem_req_wen",   mem_req_wen,   m_wen);
    chk("mem_req_wdata", mem_req_wdata, m_wdata);
    chk("mem_req_wmask", mem_req_wmask, m_wmask);
    chk("busy",          busy,          e_busy);
    if (rst) return;
    if (win >= 0) begin
      m_busy = 1; m_issued = 0; m_age = 0; m_owner = (win == 1); m_last = (win == 1);
      if (win == 1) begin
        m_addr = ls_req_addr; m_wen = ls_req_wen; m_wdata = ls_req_wdata; m_wmask = ls_req_wmask;
      end else begin
        m_addr = if_req_addr; m_wen = 0; m_wdata = '0; m_wmask = '0;
      end
    end else if (m_busy) begin
      if (done) begin
        m_busy = 0;
        $display("[TB] txn %s %s addr=0x%h data=0x%h err=%0d", m_owner ? "LS" : "IF",
                 m_wen ? "W" : "R", m_addr, rdata, err);
      end else begin
        m_age++;
        if (newly) m_issued = 1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_step();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req_valid = 0; if_req_addr = '0;
    ls_req_valid = 0; ls_req_addr = '0; ls_req_wen = 0; ls_req_wdata = '0; ls_req_wmask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  // One requester issues a read. Memory accepts it on the first ISSUE cycle
  // (or never) and optionally answers exactly on the timeout cycle.
  task automatic run_timeout(input bit use_ls, input bit accept, input bit resp_at_to);
    int  k;
    bit  got;
    logic rv, re, rdy;
    logic [63:0] rd;
    got = 0;
    clear_inputs();
    if (use_ls) begin ls_req_valid = 1; ls_req_addr = 64'h8000_2000; end
    else begin if_req_valid = 1; if_req_addr = 64'h8000_0040; end
    sample();
    rdy = use_ls ? ls_req_ready : if_req_ready;
    chk("to_grant", rdy, 1'b1);
    advance();
    if_req_valid = 0; ls_req_valid = 0;
    for (k = 1; k <= TO + 10; k++) begin
      mem_req_ready  = accept && (k == 1);
      mem_resp_valid = resp_at_to && (k == TO + 1);
      mem_resp_data  = 64'h5555_0000_1234_9999;
      sample();
      rv = use_ls ? ls_resp_valid : if_resp_valid;
      if (rv) begin got = 1; break; end
      advance();
    end
    re = use_ls ? ls_resp_err : if_resp_err;
    rd = use_ls ? ls_resp_data : if_resp_data;
    chk("to_got_resp", got, 1'b1);
    chk("to_resp_cycle", k, TO + 1);
    chk("to_resp_err", re, !resp_at_to);
    chk("to_resp_data", rd, resp_at_to ? 64'h5555_0000_1234_9999 : 64'd0);
    advance();
    clear_inputs();
    sample();
    chk("to_idle_after", busy, 1'b0);
    advance();
  endtask

  typedef struct {
    logic        rst, ifv, lsv, mrdy, mrsp;
    logic [63:0] mdata;
    logic        e_ifr, e_lsr, e_mv, e_ifp, e_lsp, e_busy;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int acc_cnt;
    bit if_pend, ls_pend;

    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,64'h0,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,64'h0,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,64'h0,    1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,64'h0,    1'b0,1'b0,1'b1,1'b0,1'b0,1'b1};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,64'h413,  1'b0,1'b0,1'b0,1'b1,1'b0,1'b1};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,64'h0,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,64'h0,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,64'h0,    1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,64'h0,    1'b0,1'b0,1'b1,1'b0,1'b0,1'b1};
    tbl[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,64'hAAAA, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1};
    tbl[10] = '{1'b0,1'b1,1'b1,1'b0,1'b0,64'h0,    1'b0,1'b1,1'b0,1'b0,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b1,1'b1,1'b1,1'b0,64'h0,    1'b0,1'b0,1'b1,1'b0,1'b0,1'b1};
    tbl[12] = '{1'b0,1'b1,1'b1,1'b0,1'b1,64'hBBBB, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};
    tbl[13] = '{1'b0,1'b1,1'b1,1'b0,1'b0,64'h0,    1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b1,1'b0,64'h0,    1'b0,1'b0,1'b1,1'b0,1'b0,1'b1};
    tbl[15] = '{1'b0,1'b0,1'b0,1'b0,1'b1,64'hCCCC, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1};
    tbl[16] = '{1'b0,1'b0,1'b0,1'b0,1'b1,64'hDDDD, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};

    rst = 1;
    clear_inputs();

    // Reset, minimum-latency fetch, round-robin on ties, response in IDLE.
    for (int i = 0; i < 17; i++) begin
      clear_inputs();
      rst = tbl[i].rst;
      if_req_valid = tbl[i].ifv; if_req_addr = 64'h8000_0000;
      ls_req_valid = tbl[i].lsv; ls_req_addr = 64'h8000_1000;
      mem_req_ready = tbl[i].mrdy; mem_resp_valid = tbl[i].mrsp; mem_resp_data = tbl[i].mdata;
      sample();
      chk($sformatf("tbl%0d_if_ready", i), if_req_ready, tbl[i].e_ifr);
      chk($sformatf("tbl%0d_ls_ready", i), ls_req_ready, tbl[i].e_lsr);
      chk($sformatf("tbl%0d_mem_valid", i), mem_req_valid, tbl[i].e_mv);
      chk($sformatf("tbl%0d_if_resp", i), if_resp_valid, tbl[i].e_ifp);
      chk($sformatf("tbl%0d_ls_resp", i), ls_resp_valid, tbl[i].e_lsp);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      if (i == 3) chk("tbl3_mem_addr", mem_req_addr, 64'h8000_0000);
      if (i == 4) chk("tbl4_if_data", if_resp_data, 64'h413);
      advance();
    end

    // Stalled LS write: fields stay stable and are accepted once, and the
    // response carries zero data.
    clear_inputs();
    acc_cnt = 0;
    ls_req_valid = 1; ls_req_wen = 1; ls_req_addr = 64'h8000_1000;
    ls_req_wdata = 64'h1122_3344_5566_7788; ls_req_wmask = 8'hFF;
    sample();
    acc_cnt += int'(ls_req_ready);
    advance();
    ls_req_valid = 0; ls_req_wdata = 64'hDEAD_DEAD_DEAD_DEAD; ls_req_addr = '0;
    for (int k = 0; k < 4; k++) begin
      mem_req_ready = (k == 3);
      sample();
      acc_cnt += int'(ls_req_ready);
      chk("wr_mem_valid", mem_req_valid, 1'b1);
      chk("wr_mem_addr", mem_req_addr, 64'h8000_1000);
      chk("wr_mem_wdata", mem_req_wdata, 64'h1122_3344_5566_7788);
      chk("wr_mem_wmask", mem_req_wmask, 8'hFF);
      chk("wr_mem_wen", mem_req_wen, 1'b1);
      advance();
    end
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 64'hCAFE_F00D_CAFE_F00D;
    sample();
    chk("wr_ls_resp_valid", ls_resp_valid, 1'b1);
    chk("wr_ls_resp_data", ls_resp_data, 64'd0);
    chk("wr_ls_resp_err", ls_resp_err, 1'b0);
    chk("wr_single_accept", acc_cnt, 1);
    advance();

    // Timeouts in WAIT and in ISSUE, and a response on the exact timeout cycle.
    run_timeout(1'b1, 1'b1, 1'b0);
    run_timeout(1'b0, 1'b0, 1'b0);
    run_timeout(1'b1, 1'b1, 1'b1);

    // Reset while in WAIT. Responses after the release must be ignored.
    clear_inputs();
    if_req_valid = 1; if_req_addr = 64'h8000_0100;
    sample(); advance();
    if_req_valid = 0; mem_req_ready = 1;
    sample(); advance();
    mem_req_ready = 0; rst = 1;
    sample();
    chk("rstw_busy", busy, 1'b0);
    advance();
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      mem_resp_valid = 1; mem_resp_data = 64'h1234;
      sample();
      chk("rstw_if_resp", if_resp_valid, 1'b0);
      chk("rstw_ls_resp", ls_resp_valid, 1'b0);
      chk("rstw_busy_after", busy, 1'b0);
      advance();
    end

    // Randomized traffic. Each requester holds its request until accepted.
    clear_inputs();
    if_pend = 0; ls_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!if_pend && $urandom_range(0, 2) != 0) begin
        if_pend = 1; if_req_addr = {$urandom, $urandom};
      end
      if (!ls_pend && $urandom_range(0, 2) != 0) begin
        ls_pend = 1; ls_req_addr = {$urandom, $urandom}; ls_req_wen = 1'($urandom);
        ls_req_wdata = {$urandom, $urandom}; ls_req_wmask = 8'($urandom);
      end
      if_req_valid = if_pend; ls_req_valid = ls_pend;
      mem_req_ready  = 1'($urandom);
      mem_resp_valid = ($urandom_range(0, 6) == 0);
      mem_resp_data  = {$urandom, $urandom};
      sample();
      if (if_req_ready) if_pend = 0;
      if (ls_req_ready) ls_pend = 0;
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
